// File: rtl/interrupt_controller_if.sv
// Processor-side address/control and interrupt lines of interrupt_controller.
// Interrupt handshake: BUS_INTERRUPT_RAISE[n] is the valid of line n and
// BUS_INTERRUPT_ACK[n] is its ready. An interrupt is taken on the rising CLK
// edge where both are 1. Once raised, RAISE holds until that edge. An ACK
// sampled while RAISE is 0 has no effect.
// BUS_DATA is a tristate net, so it stays a direct port of the controller.
interface interrupt_controller_if;
   logic [7:0] BUS_ADDR;
   logic       BUS_WE;
   logic [1:0] BUS_INTERRUPT_RAISE;
   logic [1:0] BUS_INTERRUPT_ACK;

   modport master (
      output BUS_ADDR,
      output BUS_WE,
      output BUS_INTERRUPT_ACK,
      input  BUS_INTERRUPT_RAISE
   );

   modport slave (
      input  BUS_ADDR,
      input  BUS_WE,
      input  BUS_INTERRUPT_ACK,
      output BUS_INTERRUPT_RAISE
   );
endinterface

// File: rtl/interrupt_controller.sv
// Four-source interrupt controller with two request lines to the processor.
// Sources 0-1 are served by line 0, and sources 2-3 are served by line 1.
// Within a group the lower index wins.
// Register window at BASE_ADDR (four addresses):
//   +0 MASK (R/W), +1 PENDING (R, W1C), +2 VECTOR0 (R), +3 VECTOR1 (R).
// Reads are registered, so data is driven on BUS_DATA one cycle after the address.
module interrupt_controller #(
   parameter logic [7:0] BASE_ADDR = 8'hF0
) (
   input  logic                   CLK,
   input  logic                   RESET,
   inout  wire  [7:0]             BUS_DATA,
   input  logic [3:0]             SRC_IRQ,
   interrupt_controller_if.slave  bus,
   output logic [3:0]             DBG_FSM_STATE
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RAISE   = 2'd1;
   localparam logic [1:0] ST_HOLDOFF = 2'd2;

   logic [3:0]      src_prev_q;
   logic [3:0]      mask_q, mask_d;
   logic [3:0]      pend_q, pend_d;
   logic [1:0][1:0] state_q, state_d;
   logic [1:0][1:0] id_q, id_d;
   logic [1:0][1:0] vec_q, vec_d;
   logic [7:0]      rdata_q, rdata_d;
   logic            rd_en_q, rd_en_d;

   logic [7:0]      offset;
   logic            in_window;
   logic [3:0]      src_rise;
   logic [3:0]      ack_clr;
   logic [3:0]      w1c_clr;
   logic [1:0]      grp_req;
   logic            unused_data_hi;

   // Window decode (offset subtraction tolerates any BASE_ADDR) and rising-edge detect.
   always_comb begin
      offset    = bus.BUS_ADDR - BASE_ADDR;
      in_window = (offset[7:2] == 6'd0);
      src_rise  = SRC_IRQ & ~src_prev_q;
   end

   // Per-line FSM next state: the winning ID is latched on dispatch, and the vector is written on ACK.
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      vec_d   = vec_q;
      ack_clr = 4'h0;
      grp_req = 2'b00;
      for (int n = 0; n < 2; n++) begin
         grp_req = pend_q[2*n +: 2] & mask_q[2*n +: 2];
         case (state_q[n])
            ST_IDLE: begin
               if (grp_req != 2'b00) begin
                  state_d[n] = ST_RAISE;
                  id_d[n]    = grp_req[0] ? 2'(2*n) : 2'(2*n + 1);
               end
            end
            ST_RAISE: begin
               // The mask is not consulted here, so a request that has been raised always completes.
               if (bus.BUS_INTERRUPT_ACK[n]) begin
                  state_d[n]       = ST_HOLDOFF;
                  ack_clr[id_q[n]] = 1'b1;
                  vec_d[n]         = id_q[n];
               end
            end
            ST_HOLDOFF: state_d[n] = ST_IDLE;
            default:    state_d[n] = ST_IDLE;
         endcase
      end
   end

   // Register writes, pending update (a new edge beats any clear) and registered read mux.
   always_comb begin
      mask_d  = mask_q;
      w1c_clr = 4'h0;
      if (bus.BUS_WE && in_window) begin
         if (offset[1:0] == 2'd0) mask_d  = BUS_DATA[3:0];
         if (offset[1:0] == 2'd1) w1c_clr = BUS_DATA[3:0];
      end
      pend_d  = (pend_q & ~ack_clr & ~w1c_clr) | src_rise;
      rd_en_d = ~bus.BUS_WE & in_window;
      rdata_d = 8'h00;
      if (rd_en_d) begin
         case (offset[1:0])
            2'd0:    rdata_d = {4'h0, mask_q};
            2'd1:    rdata_d = {4'h0, pend_q};
            2'd2:    rdata_d = {6'd0, vec_q[0]};
            default: rdata_d = {6'd0, vec_q[1]};
         endcase
      end
   end

   // Edge-detect copy resets to all ones, so a source already high at release is not an event.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) src_prev_q <= 4'hF;
      else       src_prev_q <= SRC_IRQ;
   end

   // Control/status registers and the line FSMs; reset discards any request in flight.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         mask_q  <= 4'h0;
         pend_q  <= 4'h0;
         state_q <= {ST_IDLE, ST_IDLE};
         id_q    <= '0;
         vec_q   <= '0;
      end else begin
         mask_q  <= mask_d;
         pend_q  <= pend_d;
         state_q <= state_d;
         id_q    <= id_d;
         vec_q   <= vec_d;
      end
   end

   // Registered read data and bus drive enable.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rdata_q <= 8'h00;
         rd_en_q <= 1'b0;
      end else begin
         rdata_q <= rdata_d;
         rd_en_q <= rd_en_d;
      end
   end

   assign BUS_DATA                = rd_en_q ? rdata_q : 8'hZZ;
   assign bus.BUS_INTERRUPT_RAISE = {state_q[1] == ST_RAISE, state_q[0] == ST_RAISE};
   assign DBG_FSM_STATE           = {state_q[1], state_q[0]};
   // The upper write-data bits have no storage behind them.
   assign unused_data_hi          = ^BUS_DATA[7:4];

endmodule
